// File: rtl/eth_txframer.sv
// Ethernet TX framer: drains the arbitrated TX FIFO (FWFT) and prepends a 16-byte
// Ethernet+shim header carrying pktdir and a 14-bit frame sequence number.
module eth_txframer #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] frame_cnt,
  output logic [31:0] underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR0    = 2'd1,
    HDR1    = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  pktdir_q, pktdir_d;
  logic [13:0] seq_q, seq_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] underrun_cnt_q, underrun_cnt_d;

  logic         load_ok;
  logic         pop;
  logic [127:0] hdr;

  // Header is assembled big-endian (byte 0 in the top bits); the wire puts byte 0 in the low lane.
  function automatic logic [63:0] wire_order(input logic [63:0] be);
    logic [63:0] le;
    le = 64'd0;
    for (int k = 0; k < 8; k++) begin
      le[8*k +: 8] = be[63-8*k -: 8];
    end
    return le;
  endfunction

  assign load_ok    = !tvalid_q || m_axis_tready;
  assign pop        = (state_q == PAYLOAD) && load_ok && !fifo_empty;
  assign fifo_rd_en = pop;
  assign hdr        = {DST_MAC, SRC_MAC, ETHERTYPE, pktdir_q, seq_q};

  // Next-state, output-register and counter computation.
  always_comb begin
    state_d        = state_q;
    pktdir_d       = pktdir_q;
    seq_d          = seq_q;
    tdata_d        = tdata_q;
    tkeep_d        = tkeep_q;
    tlast_d        = tlast_q;
    tvalid_d       = tvalid_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;

    if (tvalid_q && m_axis_tready && tlast_q) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
        if (!fifo_empty) begin
          pktdir_d = fifo_dout[75:74];
          state_d  = HDR0;
        end else begin
          state_d  = IDLE;
        end
      end
      HDR0: begin
        if (load_ok) begin
          tdata_d  = wire_order(hdr[127:64]);
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = HDR1;
        end else begin
          state_d  = HDR0;
        end
      end
      HDR1: begin
        if (load_ok) begin
          tdata_d  = wire_order(hdr[63:0]);
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = PAYLOAD;
        end else begin
          state_d  = HDR1;
        end
      end
      PAYLOAD: begin
        if (pop) begin
          tdata_d  = fifo_dout[73:10];
          tkeep_d  = fifo_dout[9:2];
          tlast_d  = fifo_dout[1];
          tvalid_d = 1'b1;
          if (fifo_dout[1]) begin
            seq_d   = seq_q + 14'd1;
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end else if (load_ok) begin
          // Register is free but nothing to fill it with: bubble, and count the starved cycle.
          tvalid_d = 1'b0;
          if (underrun_cnt_q != 32'hFFFF_FFFF) begin
            underrun_cnt_d = underrun_cnt_q + 32'd1;
          end else begin
            underrun_cnt_d = underrun_cnt_q;
          end
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pktdir_q       <= 2'd0;
      seq_q          <= 14'd0;
      tdata_q        <= 64'd0;
      tkeep_q        <= 8'd0;
      tlast_q        <= 1'b0;
      tvalid_q       <= 1'b0;
      frame_cnt_q    <= 32'd0;
      underrun_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pktdir_q       <= pktdir_d;
      seq_q          <= seq_d;
      tdata_q        <= tdata_d;
      tkeep_q        <= tkeep_d;
      tlast_q        <= tlast_d;
      tvalid_q       <= tvalid_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_cnt     = frame_cnt_q;
  assign underrun_cnt  = underrun_cnt_q;

endmodule
